// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised data/return stack.
// Contents: stack op encoding (STK_NOP..STK_CLEAR), the op-select width,
// and per-op helpers used by the legality checker.
// Ports: none (package).
package stack_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    STK_NOP         = 3'd0,
    STK_PUSH        = 3'd1,
    STK_POP         = 3'd2,
    STK_REPLACE     = 3'd3,
    STK_POP_REPLACE = 3'd4,
    STK_SWAP        = 3'd5,
    STK_DUP         = 3'd6,
    STK_CLEAR       = 3'd7
  } stack_op_e;

  // Minimum occupancy an op needs before it may execute.
  function automatic logic [1:0] min_count(input logic [OP_W-1:0] op);
    case (stack_op_e'(op))
      STK_POP, STK_REPLACE, STK_DUP: min_count = 2'd1;
      STK_POP_REPLACE, STK_SWAP:     min_count = 2'd2;
      default:                       min_count = 2'd0;
    endcase
  endfunction

  // Ops that add an entry and therefore need spare capacity.
  function automatic logic grows(input logic [OP_W-1:0] op);
    grows = (stack_op_e'(op) == STK_PUSH) || (stack_op_e'(op) == STK_DUP);
  endfunction

endpackage

// File: rtl/stack_op_check.sv
// Combinational legality check for one stack op against the current count.
// Ports:
//   stackOP    in   op select
//   count      in   occupancy before the op
//   legal      out  op may execute
//   would_ovf  out  op illegal because it would grow a full (or empty, for DUP) stack
//   would_udf  out  op illegal because too few entries are present
module stack_op_check
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic [OP_W-1:0]         stackOP,
  input  logic [$clog2(DEPTH):0]  count,
  output logic                    legal,
  output logic                    would_ovf,
  output logic                    would_udf
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic grow_c;
  logic short_c;
  logic at_cap_c;

  assign grow_c   = grows(stackOP);
  assign short_c  = count < CW'(min_count(stackOP));
  assign at_cap_c = count == CW'(DEPTH);

  assign legal     = !short_c && !(grow_c && at_cap_c);
  // Growing ops report every illegality as overflow; the rest as underflow.
  assign would_ovf = grow_c && !legal;
  assign would_udf = !grow_c && !legal;

endmodule

// File: rtl/param_register_stack.sv
// Parametrised circular register stack serving as data or return stack.
// Build option: PARAM_REGISTER_STACK_GUARD_EN suppresses illegal ops, keeps
// sticky ovf/udf flags and masks a/b when too few entries are present.
// Ports:
//   CLK      in   rising-edge clock
//   reset    in   synchronous active-low reset
//   stackOP  in   op select (stack_pkg encoding)
//   w        in   write data (new top)
//   a        out  top of stack (combinational)
//   b        out  second of stack (combinational)
//   count    out  occupancy 0..DEPTH
//   full     out  count == DEPTH
//   empty    out  count == 0
//   ovf      out  sticky overflow (guard build, else 0)
//   udf      out  sticky underflow (guard build, else 0)
module param_register_stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [OP_W-1:0]         stackOP,
  input  logic [WIDTH-1:0]        w,
  output logic [WIDTH-1:0]        a,
  output logic [WIDTH-1:0]        b,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    ovf,
  output logic                    udf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    tp_q, tp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    tp_inc_c, tp_dec_c;
  logic [CW-1:0]    count_inc_c, count_dec_c;
  logic             legal_c;

  assign tp_inc_c    = tp_q + PW'(1);
  assign tp_dec_c    = tp_q - PW'(1);
  // Occupancy saturates while the pointer keeps wrapping.
  assign count_inc_c = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
  assign count_dec_c = (count_q == CW'(0))     ? count_q : count_q - CW'(1);

`ifdef PARAM_REGISTER_STACK_GUARD_EN
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic would_ovf_c, would_udf_c;

  stack_op_check #(.DEPTH(DEPTH)) u_op_check (
    .stackOP   (stackOP),
    .count     (count_q),
    .legal     (legal_c),
    .would_ovf (would_ovf_c),
    .would_udf (would_udf_c)
  );
`else
  assign legal_c = 1'b1;
`endif

  // Next-state: each op rewrites at most two mem slots plus pointer/count.
  always_comb begin
    mem_d   = mem_q;
    tp_d    = tp_q;
    count_d = count_q;
`ifdef PARAM_REGISTER_STACK_GUARD_EN
    ovf_d   = ovf_q | would_ovf_c;
    udf_d   = udf_q | would_udf_c;
`endif
    if (legal_c) begin
      case (stack_op_e'(stackOP))
        STK_PUSH: begin
          tp_d            = tp_inc_c;
          mem_d[tp_inc_c] = w;
          count_d         = count_inc_c;
        end
        STK_POP: begin
          tp_d    = tp_dec_c;
          count_d = count_dec_c;
        end
        STK_REPLACE: begin
          mem_d[tp_q] = w;
        end
        STK_POP_REPLACE: begin
          tp_d            = tp_dec_c;
          mem_d[tp_dec_c] = w;
          count_d         = count_dec_c;
        end
        STK_SWAP: begin
          mem_d[tp_q]     = mem_q[tp_dec_c];
          mem_d[tp_dec_c] = mem_q[tp_q];
        end
        STK_DUP: begin
          tp_d            = tp_inc_c;
          mem_d[tp_inc_c] = mem_q[tp_q];
          count_d         = count_inc_c;
        end
        STK_CLEAR: begin
          tp_d    = PW'(DEPTH - 1);
          count_d = '0;
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      tp_q    <= PW'(DEPTH - 1);
      count_q <= '0;
`ifdef PARAM_REGISTER_STACK_GUARD_EN
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
`endif
    end else begin
      mem_q   <= mem_d;
      tp_q    <= tp_d;
      count_q <= count_d;
`ifdef PARAM_REGISTER_STACK_GUARD_EN
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
`endif
    end
  end

  assign count = count_q;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == CW'(0);

`ifdef PARAM_REGISTER_STACK_GUARD_EN
  // Slots below the live entries read as zero.
  assign a   = (count_q >= CW'(1)) ? mem_q[tp_q]     : '0;
  assign b   = (count_q >= CW'(2)) ? mem_q[tp_dec_c] : '0;
  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign a   = mem_q[tp_q];
  assign b   = mem_q[tp_dec_c];
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_param_register_stack.sv
// Scoreboard bench for param_register_stack (DEPTH=4 to reach wrap quickly).
// Stimulus pushes the reference model's expected view into a queue; a
// separate monitor pops it just after every rising edge and compares.
module tb_param_register_stack;
  import stack_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             CLK = 1'b0;
  logic             reset;
  logic [OP_W-1:0]  stackOP;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] a, b;
  logic [CW-1:0]    count;
  logic             full, empty, ovf, udf;

  param_register_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .stackOP (stackOP),
    .w       (w),
    .a       (a),
    .b       (b),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .udf     (udf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int a;
    int b;
    int cnt;
    int full;
    int empty;
    int ovf;
    int udf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

`ifdef PARAM_REGISTER_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // Reference model: circular array with integer pointer and occupancy.
  int m_mem [DEPTH];
  int m_tp;
  int m_cnt;
  int m_ovf;
  int m_udf;

  function automatic int below(input int p);
    return (p + DEPTH - 1) % DEPTH;
  endfunction

  task automatic model_apply(input bit rst_n, input int op, input int wv);
    int need;
    bit adds;
    int tmp;
    if (!rst_n) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_tp  = DEPTH - 1;
      m_cnt = 0;
      m_ovf = 0;
      m_udf = 0;
      return;
    end
    adds = (op == 1) || (op == 6);
    need = (op == 4 || op == 5) ? 2 : (op == 2 || op == 3 || op == 6) ? 1 : 0;
    if (GUARD && (m_cnt < need || (adds && m_cnt == DEPTH))) begin
      if (adds) m_ovf = 1; else m_udf = 1;
      return;
    end
    case (op)
      1: begin m_tp = (m_tp + 1) % DEPTH; m_mem[m_tp] = wv; end
      2: m_tp = below(m_tp);
      3: m_mem[m_tp] = wv;
      4: begin m_tp = below(m_tp); m_mem[m_tp] = wv; end
      5: begin
        tmp = m_mem[m_tp];
        m_mem[m_tp] = m_mem[below(m_tp)];
        m_mem[below(m_tp)] = tmp;
      end
      6: begin tmp = m_mem[m_tp]; m_tp = (m_tp + 1) % DEPTH; m_mem[m_tp] = tmp; end
      7: begin m_tp = DEPTH - 1; m_cnt = 0; end
      default: ;
    endcase
    if (adds && m_cnt < DEPTH) m_cnt++;
    if ((op == 2 || op == 4) && m_cnt > 0) m_cnt--;
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.a     = m_mem[m_tp];
    e.b     = m_mem[below(m_tp)];
    if (GUARD && m_cnt < 1) e.a = 0;
    if (GUARD && m_cnt < 2) e.b = 0;
    e.cnt   = m_cnt;
    e.full  = (m_cnt == DEPTH) ? 1 : 0;
    e.empty = (m_cnt == 0) ? 1 : 0;
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Drive one op, record the model's expected post-edge view, then step past the edge.
  task automatic step(input bit rst_n, input int op, input int wv);
    reset   = rst_n;
    stackOP = OP_W'(op);
    w       = WIDTH'(wv);
    model_apply(rst_n, op, wv & 16'hFFFF);
    exp_q.push_back(model_view());
    @(posedge CLK);
    #2;
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_a",     int'(a),     e.a);
        check("sb_b",     int'(b),     e.b);
        check("sb_count", int'(count), e.cnt);
        check("sb_full",  int'(full),  e.full);
        check("sb_empty", int'(empty), e.empty);
        check("sb_ovf",   int'(ovf),   e.ovf);
        check("sb_udf",   int'(udf),   e.udf);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain;
    reset   = 1'b0;
    stackOP = '0;
    w       = '0;

    // Reset, and a PUSH coinciding with reset must be ignored.
    step(0, 0, 0);
    step(0, 1, 16'hBEEF);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);

    step(1, 1, 16'h0011);
    step(1, 1, 16'h0022);
    step(1, 1, 16'h0033);
    check("push3_a", int'(a), 16'h0033);
    check("push3_b", int'(b), 16'h0022);
    check("push3_count", int'(count), 3);
    check("push3_empty", int'(empty), 0);

    step(1, 5, 0);
    check("swap_a", int'(a), 16'h0022);
    check("swap_b", int'(b), 16'h0033);
    step(1, 4, 16'h0055);
    check("popr_a", int'(a), 16'h0055);
    check("popr_b", int'(b), 16'h0011);
    check("popr_count", int'(count), 2);

    step(1, 6, 0);
    check("dup_a", int'(a), 16'h0055);
    check("dup_b", int'(b), 16'h0055);
    check("dup_count", int'(count), 3);
    step(1, 7, 0);
    check("clear_count", int'(count), 0);
    check("clear_empty", int'(empty), 1);

    for (int i = 1; i <= 5; i++) step(1, 1, i);
    if (GUARD) begin
      check("ovf_a", int'(a), 4);
      check("ovf_flag", int'(ovf), 1);
      check("ovf_count", int'(count), 4);
      for (int i = 0; i < 5; i++) step(1, 2, 0);
      check("udf_count", int'(count), 0);
      check("udf_flag", int'(udf), 1);
      check("udf_a", int'(a), 0);
      check("udf_b", int'(b), 0);
    end else begin
      check("wrap_full", int'(full), 1);
      check("wrap_count", int'(count), 4);
      check("wrap_a", int'(a), 5);
      check("wrap_b", int'(b), 4);
      for (int i = 0; i < 4; i++) step(1, 2, 0);
      check("wrap_pop_a", int'(a), 5);
    end

    // Reset asserted during a PUSH with two entries present.
    step(0, 0, 0);
    step(1, 1, 16'h0101);
    step(1, 1, 16'h0202);
    step(0, 1, 16'h0303);
    check("rstpush_count", int'(count), 0);
    check("rstpush_a", int'(a), 0);
    check("rstpush_ovf", int'(ovf), 0);
    check("rstpush_udf", int'(udf), 0);

    // Random back-to-back ops with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) != 0), int'($urandom_range(7)), int'($urandom_range(16'hFFFF)));
    end

    drain = 0;
    while (exp_q.size() != 0 && drain < 10) begin
      @(posedge CLK);
      #2;
      drain++;
    end
    if (exp_q.size() != 0) check("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
